i2c_target_regbank: RTL and testbench

I2C target (responder) that lets an external I2C initiator (MCU or the on-board I2C controller in loopback) read and write an 8-bit-wide register space inside the FPGA. It is the other end of the ADC configuration bus: the same byte-oriented write/read framing the controllers emit, decoded into single-cycle register strobes. It sits between the board-level `scl`/`sda` pins and a register bank owned by the DSP datapath; no clock stretching.

---
 rtl/i2c_target_regbank.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_target_regbank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regbank.sv
// I2C target bridging an external initiator to an 8-bit register bank through
// single-cycle write/read strobes. Open-drain SDA, no clock stretching.
module i2c_target_regbank #(
   parameter logic [6:0] DEV_ADDR = 7'h40,
   parameter int         AW       = 8,
   parameter int         FILT     = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl,
   inout  wire           sda,
   output logic [AW-1:0] reg_addr,
   output logic [7:0]    reg_wdata,
   output logic          reg_wr,
   output logic          reg_rd,
   input  logic [7:0]    reg_rdata,
   output logic          busy,
   output logic          nack_seen
);
   localparam int CW = (FILT > 1) ? $clog2(FILT + 1) : 1;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   // index 0 = SCL, 1 = SDA
   logic [1:0]          s1_q, s2_q, f_q, fp_q;
   logic [1:0][CW-1:0]  cnt_q;

   state_t        state_q, state_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d, rbuf_q, rbuf_d, wdata_q, wdata_d;
   logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d;
   logic          rw_q, rw_d, sda_low_q, sda_low_d, busy_q, busy_d;
   logic          wr_q, wr_d, rd_q, rd_d, rd_pend_q, nack_q, nack_d;
   logic          scl_rise, scl_fall, start_c, stop_c, sda_drv;
   logic [7:0]    byte_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q  <= 2'b11;
         s2_q  <= 2'b11;
         f_q   <= 2'b11;
         fp_q  <= 2'b11;
         cnt_q <= '0;
      end else begin
         s1_q <= {sda, scl};
         s2_q <= s1_q;
         fp_q <= f_q;
         for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == f_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CW'(FILT - 1)) begin
               f_q[i]   <= s2_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign scl_rise = f_q[0] & ~fp_q[0];
   assign scl_fall = ~f_q[0] & fp_q[0];
   assign start_c  = f_q[0] & fp_q[1] & ~f_q[1];
   assign stop_c   = f_q[0] & ~fp_q[1] & f_q[1];
   assign byte_c   = {shift_q[6:0], f_q[1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         rbuf_q    <= '0;
         wdata_q   <= '0;
         ptr_q     <= '0;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         sda_low_q <= 1'b0;
         busy_q    <= 1'b0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         rd_pend_q <= 1'b0;
         nack_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         rbuf_q    <= rbuf_d;
         wdata_q   <= wdata_d;
         ptr_q     <= ptr_d;
         addr_q    <= addr_d;
         rw_q      <= rw_d;
         sda_low_q <= sda_low_d;
         busy_q    <= busy_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         rd_pend_q <= rd_q;
         nack_q    <= nack_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      shift_d   = shift_q;
      rbuf_d    = rd_pend_q ? reg_rdata : rbuf_q;
      wdata_d   = wdata_q;
      ptr_d     = wr_q ? ptr_q + 1'b1 : ptr_q;
      addr_d    = addr_q;
      rw_d      = rw_q;
      sda_low_d = sda_low_q;
      busy_d    = busy_q;
      wr_d      = 1'b0;
      rd_d      = 1'b0;
      nack_d    = 1'b0;
      if (start_c) begin
         state_d   = ADDR;
         bitcnt_d  = '0;
         sda_low_d = 1'b0;
      end else if (stop_c) begin
         state_d   = IDLE;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            ADDR, PTR, WDATA: if (scl_rise) begin
               shift_d  = byte_c;
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == 4'd7) begin
                  if (state_q == PTR) begin
                     ptr_d   = AW'(byte_c);
                     state_d = PTR_ACK;
                  end else if (state_q == WDATA) begin
                     wr_d    = 1'b1;
                     addr_d  = ptr_q;
                     wdata_d = byte_c;
                     state_d = WDATA_ACK;
                  end else if (byte_c[7:1] == DEV_ADDR && byte_c[7:1] != 7'd0) begin
                     state_d = ADDR_ACK;
                     busy_d  = 1'b1;
                     rw_d    = byte_c[0];
                     rd_d    = byte_c[0];
                     if (byte_c[0]) addr_d = ptr_q;
                  end else begin
                     state_d = WAIT_STOP;
                     busy_d  = 1'b0;
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (scl_rise) bitcnt_d = bitcnt_q + 1'b1;
               if (scl_fall) begin
                  if (bitcnt_q == 4'd8) begin
                     sda_low_d = 1'b1;
                  end else begin
                     bitcnt_d = '0;
                     if (state_q == ADDR_ACK && rw_q) begin
                        state_d   = RDATA;
                        sda_low_d = ~rbuf_q[7];
                        rbuf_d    = {rbuf_q[6:0], 1'b0};
                     end else begin
                        state_d   = (state_q == ADDR_ACK) ? PTR : WDATA;
                        sda_low_d = 1'b0;
                     end
                  end
               end
            end
            RDATA: begin
               if (scl_fall) begin
                  sda_low_d = ~rbuf_q[7];
                  rbuf_d    = {rbuf_q[6:0], 1'b0};
               end
               if (scl_rise) begin
                  bitcnt_d = bitcnt_q + 1'b1;
                  if (bitcnt_q == 4'd7) state_d = RDATA_ACK;
               end
            end
            RDATA_ACK: begin
               if (scl_fall) begin
                  if (bitcnt_q == 4'd8) begin
                     sda_low_d = 1'b0;
                  end else begin
                     bitcnt_d  = '0;
                     state_d   = RDATA;
                     sda_low_d = ~rbuf_q[7];
                     rbuf_d    = {rbuf_q[6:0], 1'b0};
                  end
               end
               if (scl_rise) begin
                  bitcnt_d = bitcnt_q + 1'b1;
                  if (f_q[1]) begin
                     nack_d  = 1'b1;
                     state_d = WAIT_STOP;
                     busy_d  = 1'b0;
                  end else begin
                     ptr_d  = ptr_q + 1'b1;
                     addr_d = ptr_q + 1'b1;
                     rd_d   = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      reg_addr  = addr_q;
      reg_wdata = wdata_q;
      reg_wr    = wr_q;
      reg_rd    = rd_q;
      busy      = busy_q;
      nack_seen = nack_q;
      sda_drv   = sda_low_q;
   end

   assign sda = sda_drv ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_target_regbank.sv
// Directed bench for i2c_target_regbank: bit-banged initiator plus a strobe
// scoreboard fed by the stimulus and drained by a strobe monitor.
module tb_i2c_target_regbank;
   localparam int Q = 10;

   typedef struct packed {
      logic       wr;
      logic [7:0] a;
      logic [7:0] d;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       m_low = 1'b0;
   wire        sda_w;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_wr, reg_rd, busy, nack_seen;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  nacks = 0;

   pullup (sda_w);
   assign sda_w = m_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_target_regbank #(.DEV_ADDR(7'h40), .AW(8), .FILT(3)) dut (
      .clk(clk), .rst(rst), .scl(scl_m), .sda(sda_w),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_rdata(reg_rdata), .busy(busy), .nack_seen(nack_seen)
   );

   function automatic logic [7:0] bank_val(input logic [7:0] a);
      case (a)
         8'h10:   return 8'h11;
         8'h11:   return 8'h22;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk) if (reg_rd) reg_rdata <= bank_val(reg_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      ev_t o, e;
      if (!rst) begin
         if (reg_wr || reg_rd) begin
            o = '{wr: reg_wr, a: reg_addr, d: (reg_wr ? reg_wdata : 8'h00)};
            chk("strobe_excl", {31'd0, reg_wr & reg_rd}, 32'd0);
            chk("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("strobe", {15'd0, o}, {15'd0, e});
            end
         end
         if (nack_seen) nacks++;
      end
   end

   task automatic wt(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_low = 1'b0; wt(Q);
      scl_m = 1'b1; wt(Q);
      m_low = 1'b1; wt(Q);
      scl_m = 1'b0; wt(Q);
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; wt(Q);
      scl_m = 1'b1; wt(Q);
      m_low = 1'b0; wt(Q);
   endtask

   task automatic clk_bit(input logic b, output logic r, input bit glitch);
      m_low = ~b; wt(Q);
      scl_m = 1'b1; wt(Q / 2);
      if (glitch) begin
         scl_m = 1'b0; wt(1); scl_m = 1'b1; wt(2);
         m_low = ~m_low; wt(1); m_low = ~m_low; wt(2);
      end
      r = sda_w;
      wt(Q / 2);
      scl_m = 1'b0; wt(Q);
   endtask

   task automatic wbyte(input logic [7:0] b, output logic ack, input bit glitch);
      logic r;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], r, glitch);
      clk_bit(1'b1, ack, 1'b0);
   endtask

   task automatic rbyte(input logic ackbit, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, r, 1'b0);
         b[i] = r;
      end
      clk_bit(ackbit, r, 1'b0);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      wt(4);
      chk("reset_outputs", {12'd0, reg_addr, reg_wdata, reg_wr, reg_rd, busy, nack_seen}, 32'd0);
      chk("reset_sda", {31'd0, sda_w}, 32'd1);
      rst = 1'b0;
      wt(10);

      // write two bytes from pointer 5
      exp_q.push_back('{wr: 1'b1, a: 8'h05, d: 8'hA5});
      exp_q.push_back('{wr: 1'b1, a: 8'h06, d: 8'h3C});
      i2c_start();
      wbyte(8'h80, ack, 1'b0); chk("wr_addr_ack", {31'd0, ack}, 32'd0);
      chk("busy_after_match", {31'd0, busy}, 32'd1);
      wbyte(8'h05, ack, 1'b0); chk("wr_ptr_ack", {31'd0, ack}, 32'd0);
      wbyte(8'hA5, ack, 1'b0); chk("wr_d0_ack", {31'd0, ack}, 32'd0);
      wbyte(8'h3C, ack, 1'b0); chk("wr_d1_ack", {31'd0, ack}, 32'd0);
      i2c_stop(); wt(20);
      chk("busy_after_stop", {31'd0, busy}, 32'd0);
      chk("wr_queue_drained", exp_q.size(), 32'd0);

      // pointer write, repeated start, two-byte read
      exp_q.push_back('{wr: 1'b0, a: 8'h10, d: 8'h00});
      exp_q.push_back('{wr: 1'b0, a: 8'h11, d: 8'h00});
      i2c_start();
      wbyte(8'h80, ack, 1'b0); chk("rd_addrw_ack", {31'd0, ack}, 32'd0);
      wbyte(8'h10, ack, 1'b0); chk("rd_ptr_ack", {31'd0, ack}, 32'd0);
      i2c_start();
      wbyte(8'h81, ack, 1'b0); chk("rd_addrr_ack", {31'd0, ack}, 32'd0);
      rbyte(1'b0, d); chk("rd_byte0", {24'd0, d}, 32'h11);
      rbyte(1'b1, d); chk("rd_byte1", {24'd0, d}, 32'h22);
      i2c_stop(); wt(20);
      chk("nack_pulses", nacks, 32'd1);
      chk("rd_queue_drained", exp_q.size(), 32'd0);
      chk("busy_after_read", {31'd0, busy}, 32'd0);

      // address mismatch
      i2c_start();
      wbyte(8'h84, ack, 1'b0); chk("mismatch_nack", {31'd0, ack}, 32'd1);
      chk("mismatch_busy", {31'd0, busy}, 32'd0);
      wbyte(8'h05, ack, 1'b0); chk("mismatch_ignored", {31'd0, ack}, 32'd1);
      i2c_stop(); wt(20);

      // pointer wrap
      exp_q.push_back('{wr: 1'b1, a: 8'hFF, d: 8'h01});
      exp_q.push_back('{wr: 1'b1, a: 8'h00, d: 8'h02});
      i2c_start();
      wbyte(8'h80, ack, 1'b0); chk("wrap_addr_ack", {31'd0, ack}, 32'd0);
      wbyte(8'hFF, ack, 1'b0); chk("wrap_ptr_ack", {31'd0, ack}, 32'd0);
      wbyte(8'h01, ack, 1'b0); chk("wrap_d0_ack", {31'd0, ack}, 32'd0);
      wbyte(8'h02, ack, 1'b0); chk("wrap_d1_ack", {31'd0, ack}, 32'd0);
      i2c_stop(); wt(20);
      chk("wrap_queue_drained", exp_q.size(), 32'd0);

      // single-cycle SCL/SDA glitches inside every bit
      exp_q.push_back('{wr: 1'b1, a: 8'h20, d: 8'h5A});
      i2c_start();
      wbyte(8'h80, ack, 1'b1); chk("glitch_addr_ack", {31'd0, ack}, 32'd0);
      wbyte(8'h20, ack, 1'b1); chk("glitch_ptr_ack", {31'd0, ack}, 32'd0);
      wbyte(8'h5A, ack, 1'b1); chk("glitch_data_ack", {31'd0, ack}, 32'd0);
      i2c_stop(); wt(20);
      chk("glitch_queue_drained", exp_q.size(), 32'd0);

      // reset while the target drives a 0 data bit
      exp_q.push_back('{wr: 1'b0, a: 8'h30, d: 8'h00});
      i2c_start();
      wbyte(8'h80, ack, 1'b0);
      wbyte(8'h30, ack, 1'b0);
      i2c_start();
      wbyte(8'h81, ack, 1'b0); chk("rst_rd_ack", {31'd0, ack}, 32'd0);
      chk("rst_target_drives", {31'd0, sda_w}, 32'd0);
      rst = 1'b1; wt(1);
      chk("rst_sda_released", {31'd0, sda_w}, 32'd1);
      chk("rst_mid_outputs", {12'd0, reg_addr, reg_wdata, reg_wr, reg_rd, busy, nack_seen}, 32'd0);
      rst = 1'b0;
      scl_m = 1'b1; m_low = 1'b0; wt(20);
      exp_q.push_back('{wr: 1'b1, a: 8'h07, d: 8'h99});
      i2c_start();
      wbyte(8'h80, ack, 1'b0); chk("post_rst_addr_ack", {31'd0, ack}, 32'd0);
      wbyte(8'h07, ack, 1'b0); chk("post_rst_ptr_ack", {31'd0, ack}, 32'd0);
      wbyte(8'h99, ack, 1'b0); chk("post_rst_data_ack", {31'd0, ack}, 32'd0);
      i2c_stop(); wt(20);
      chk("final_queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
